// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encoding and counter-width helper for the universal shift register
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'd0,
        USR_SHR  = 2'd1,
        USR_SHL  = 2'd2,
        USR_LOAD = 2'd3
    } usr_mode_e;

    function automatic int usr_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// usr_frame_counter: saturating shift counter that flags a full word shifted since the last clear
module usr_frame_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = usr_cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] shift_cnt,
    output logic          frame_done
);

    assign frame_done = (shift_cnt == CW'(WIDTH));

    // clear wins over increment; increment stops once a full word has been counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shift_cnt <= '0;
        else if (ena)
            shift_cnt <= clr ? '0 : (inc && !frame_done) ? shift_cnt + CW'(1) : shift_cnt;
    end

endmodule

// File: rtl/usr_shift_register.sv
// usr_shift_register: universal shift register with parallel load/readout and frame counter.
// Define USR_ROTATE_EN to add the rot input, which turns shifts into rotations.
module usr_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CW          = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    usr_mode_e        op;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             in_r;
    logic             in_l;

    assign op        = usr_mode_e'(mode);
    assign par_out   = q;
    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

    // pick the bit entering each end: the serial pin, or the bit leaving the other end when rotating
    always_comb begin
`ifdef USR_ROTATE_EN
        in_r = rot ? q[0] : ser_in_r;
        in_l = rot ? q[WIDTH-1] : ser_in_l;
`else
        in_r = ser_in_r;
        in_l = ser_in_l;
`endif
        q_next = (op == USR_SHR)  ? {in_r, q[WIDTH-1:1]} :
                 (op == USR_SHL)  ? {q[WIDTH-2:0], in_l} :
                 (op == USR_LOAD) ? par_in : q;
    end

    // register contents, updated only on enabled edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VALUE;
        else if (ena)
            q <= q_next;
    end

    usr_frame_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .clr        (op == USR_LOAD),
        .inc        (op == USR_SHR || op == USR_SHL),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_usr_shift_register.sv
// tb_usr_shift_register: scoreboard bench for usr_shift_register at WIDTH=8, RESET_VALUE=0
module tb_usr_shift_register;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       fd;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       ena = 0;
    logic [1:0] mode = 0;
    logic       ser_in_r = 0;
    logic       ser_in_l = 0;
    logic [7:0] par_in = 0;
`ifdef USR_ROTATE_EN
    logic       rot = 0;
`endif
    logic [7:0] par_out;
    logic       ser_out_r;
    logic       ser_out_l;
    logic [3:0] shift_cnt;
    logic       frame_done;

    logic [7:0] mq = 0;
    logic [3:0] mcnt = 0;
    exp_t       sb[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;

    usr_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .mode       (mode),
        .ser_in_r   (ser_in_r),
        .ser_in_l   (ser_in_l),
        .par_in     (par_in),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .par_out    (par_out),
        .ser_out_r  (ser_out_r),
        .ser_out_l  (ser_out_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // drive one cycle, advance the reference model and queue the expected post-edge state
    task automatic drive(input logic [1:0] m, input logic sr, input logic sl,
                         input logic [7:0] pin, input logic en, input logic rt);
        exp_t x;
        mode = m; ser_in_r = sr; ser_in_l = sl; par_in = pin; ena = en;
`ifdef USR_ROTATE_EN
        rot = rt;
`endif
        if (en) begin
            if (m == 2'b01) begin
                mq = {(rt ? mq[0] : sr), mq[7:1]};
                mcnt = (mcnt == 8) ? 4'd8 : mcnt + 4'd1;
            end else if (m == 2'b10) begin
                mq = {mq[6:0], (rt ? mq[7] : sl)};
                mcnt = (mcnt == 8) ? 4'd8 : mcnt + 4'd1;
            end else if (m == 2'b11) begin
                mq = pin;
                mcnt = 0;
            end
        end
        x.q = mq; x.cnt = mcnt; x.fd = (mcnt == 8);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        #2;
        total++;
        if (par_out !== 8'h00 || shift_cnt !== 4'd0 || frame_done !== 1'b0 || ser_out_r !== 1'b0 || ser_out_l !== 1'b0) begin
            bad++;
            $display("FAIL reset_init q=%h cnt=%0d fd=%b sr=%b sl=%b want 00/0/0/0/0", par_out, shift_cnt, frame_done, ser_out_r, ser_out_l);
        end
        @(negedge clk);
        rst = 0;
        mq = 0; mcnt = 0;
        @(posedge clk); #1;
        drive(2'b11, 0, 0, 8'hA5, 1, 0);
        e = sb.pop_front();
        drive(2'b01, 1, 0, 8'h00, 1, 0);
        e = sb.pop_front();
        total++;
        if (par_out !== 8'hD2 || shift_cnt !== 4'd1) begin
            bad++;
            $display("FAIL reset_preshift q=%h cnt=%0d want d2/1", par_out, shift_cnt);
        end
        #1 rst = 1;
        #1;
        total++;
        if (par_out !== 8'h00 || shift_cnt !== 4'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async q=%h cnt=%0d fd=%b want 00/0/0", par_out, shift_cnt, frame_done);
        end
        #1 rst = 0;
        mq = 0; mcnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_shift_right;
        logic [7:0] seq;
        seq = 8'b1010_0101;
        drive(2'b11, 0, 0, 8'hA5, 1, 0);
        e = sb.pop_front();
        total++;
        if (par_out !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd) begin
            bad++;
            $display("FAIL shr_load q=%h cnt=%0d fd=%b want %h/%0d/%b", par_out, shift_cnt, frame_done, e.q, e.cnt, e.fd);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ser_out_r !== seq[i]) begin
                bad++;
                $display("FAIL shr_serout%0d got=%b want=%b", i, ser_out_r, seq[i]);
            end
            drive(2'b01, 1, 0, 8'h00, 1, 0);
            e = sb.pop_front();
            total++;
            if (par_out !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd || ser_out_r !== e.q[0] || ser_out_l !== e.q[7]) begin
                bad++;
                $display("FAIL shr_step%0d q=%h cnt=%0d fd=%b want %h/%0d/%b", i, par_out, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
        total++;
        if (par_out !== 8'hFF || frame_done !== 1'b1) begin
            bad++;
            $display("FAIL shr_final q=%h fd=%b want ff/1", par_out, frame_done);
        end
    endtask

    task automatic test_shift_left;
        drive(2'b11, 0, 0, 8'h81, 1, 0);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 0, 0, 8'h00, 1, 0);
            e = sb.pop_front();
            total++;
            if (par_out !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd || ser_out_l !== e.q[7]) begin
                bad++;
                $display("FAIL shl_step%0d q=%h cnt=%0d fd=%b want %h/%0d/%b", i, par_out, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
        total++;
        if (par_out !== 8'h08 || shift_cnt !== 4'd3 || ser_out_l !== 1'b0) begin
            bad++;
            $display("FAIL shl_final q=%h cnt=%0d sl=%b want 08/3/0", par_out, shift_cnt, ser_out_l);
        end
    endtask

    task automatic test_saturation;
        drive(2'b11, 0, 0, 8'h00, 1, 0);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            drive((i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), 8'h00, 1, 0);
            e = sb.pop_front();
            total++;
            if (par_out !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd) begin
                bad++;
                $display("FAIL sat_step%0d q=%h cnt=%0d fd=%b want %h/%0d/%b", i, par_out, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
        total++;
        if (shift_cnt !== 4'd8 || frame_done !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold cnt=%0d fd=%b want 8/1", shift_cnt, frame_done);
        end
        drive(2'b11, 0, 0, 8'h3C, 1, 0);
        e = sb.pop_front();
        total++;
        if (par_out !== 8'h3C || shift_cnt !== 4'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL sat_reload q=%h cnt=%0d fd=%b want 3c/0/0", par_out, shift_cnt, frame_done);
        end
    endtask

    task automatic test_enable;
        drive(2'b11, 0, 0, 8'h5A, 1, 0);
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1, 1, 8'h00, 0, 0);
            e = sb.pop_front();
        end
        drive(2'b11, 0, 0, 8'hFF, 0, 0);
        e = sb.pop_front();
        total++;
        if (par_out !== 8'h5A || shift_cnt !== 4'd0 || par_out !== e.q) begin
            bad++;
            $display("FAIL ena_gate q=%h cnt=%0d want 5a/0", par_out, shift_cnt);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 0);
            e = sb.pop_front();
            total++;
            if (par_out !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd || ser_out_r !== e.q[0] || ser_out_l !== e.q[7]) begin
                bad++;
                $display("FAIL b2b_step%0d q=%h cnt=%0d fd=%b want %h/%0d/%b", i, par_out, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate;
        drive(2'b11, 0, 0, 8'h81, 1, 0);
        e = sb.pop_front();
        drive(2'b01, 0, 0, 8'h00, 1, 1);
        e = sb.pop_front();
        total++;
        if (par_out !== 8'hC0 || shift_cnt !== 4'd1 || par_out !== e.q) begin
            bad++;
            $display("FAIL rot_right q=%h cnt=%0d want c0/1", par_out, shift_cnt);
        end
        drive(2'b10, 0, 0, 8'h00, 1, 1);
        e = sb.pop_front();
        drive(2'b10, 0, 0, 8'h00, 1, 1);
        e = sb.pop_front();
        total++;
        if (par_out !== 8'h03 || shift_cnt !== 4'd3 || par_out !== e.q) begin
            bad++;
            $display("FAIL rot_left q=%h cnt=%0d want 03/3", par_out, shift_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left();
        test_saturation();
        test_enable();
        test_back_to_back();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_shift_register.md
# usr_shift_register

Parametrised universal shift register, the successor to the fixed serial-in/serial-out left/right register behind the tt_um top level. Adds configurable width, parallel load and parallel readout, independent serial inputs per direction, and a shift counter that flags when a full word has been shifted since the last load. The block is instantiated behind a tt_um wrapper: ui_in drives the control and serial pins, uo_out carries the outputs.

## Interface
- WIDTH, 8, register width in bits; legal range 2 to 32.
- RESET_VALUE, 0, WIDTH-bit value loaded into the register on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  clock enable; when low, all state holds.
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- ser_in_r  in  1  serial input entering the MSB on a right shift.
- ser_in_l  in  1  serial input entering the LSB on a left shift.
- par_in  in  WIDTH  parallel load data.
- par_out  out  WIDTH  current register contents, q.
- ser_out_r  out  1  q[0], the bit leaving on a right shift.
- ser_out_l  out  1  q[WIDTH-1], the bit leaving on a left shift.
- shift_cnt  out  clog2(WIDTH+1)  number of shifts since the last load or reset; saturates at WIDTH.
- frame_done  out  1  high while shift_cnt == WIDTH.

## Operation
- All state updates on the rising edge of clk, and only when ena is 1.
- 00 hold: q and shift_cnt unchanged.
- 01 shift right: q <= {ser_in_r, q[WIDTH-1:1]}; shift_cnt increments, saturating at WIDTH.
- 10 shift left: q <= {q[WIDTH-2:0], ser_in_l}; shift_cnt increments, saturating at WIDTH.
- 11 parallel load: q <= par_in; shift_cnt <= 0.
- Changing direction between shifts does not clear the counter. Shifts in both directions count together.
- Once saturated, shift_cnt stays at WIDTH through further shifts until the next load or reset. q keeps shifting normally.
- frame_done is decoded from the registered shift_cnt. It is glitch-free and needs no separate state.
- ser_out_r, ser_out_l and par_out are pure wires from q. They have no extra register stage.

## Timing
- Reset state: q = RESET_VALUE, shift_cnt = 0, frame_done = 0, ser_out_r = RESET_VALUE[0], ser_out_l = RESET_VALUE[WIDTH-1].
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- After reset deasserts, the first rising edge with ena = 1 performs the selected operation.
- Latency is one cycle: a load or shift sampled at edge N is visible on every output after edge N.
- frame_done rises in the same cycle that shift_cnt reaches WIDTH, i.e. after the WIDTH-th shift edge.
- ena low on an edge: q and shift_cnt hold regardless of mode. A load is not captured.
- mode and serial inputs are sampled only at the clock edge. They have no handshake.

## Configuration
- USR_ROTATE_EN defined:
  - Adds an input port rot (1 bit).
  - With rot = 1, shift right becomes q <= {q[0], q[WIDTH-1:1]} and shift left becomes q <= {q[WIDTH-2:0], q[WIDTH-1]}. The ser_in_* inputs are ignored.
  - Rotations count in shift_cnt exactly like shifts.
- USR_ROTATE_EN undefined: the rot port is absent and shifts always take the serial inputs. The rotate logic is not built.

## Structure
- Package usr_pkg holds:
  - typedef usr_mode_e, a 2-bit enum: USR_HOLD = 0, USR_SHR = 1, USR_SHL = 2, USR_LOAD = 3.
  - function usr_cnt_w(width), returning clog2(width+1).
- Sub-module usr_frame_counter:
  - Saturating counter with clear, increment and enable inputs, parameterised by WIDTH.
  - Outputs shift_cnt and frame_done.
- The top module holds q and the mode mux.

## Test plan
All scenarios use WIDTH = 8 and RESET_VALUE = 0.
- Reset: assert rst asynchronously mid-shift with q = 8'hA5 -> q = 8'h00, shift_cnt = 0 and frame_done = 0 before the next edge.
- Load then shift right: load 8'hA5, then shift right 8 cycles with ser_in_r = 1 -> ser_out_r sequence 1,0,1,0,0,1,0,1; final q = 8'hFF; frame_done rises after the 8th shift edge.
- Shift left: load 8'h81, then shift left 3 cycles with ser_in_l = 0 -> q = 8'h08; shift_cnt = 3; ser_out_l = 0.
- Saturation and reload: 10 shifts -> shift_cnt holds at 8 and frame_done stays 1; then mode 11 with par_in = 8'h3C -> q = 8'h3C, shift_cnt = 0, frame_done = 0.
- Enable gating: load 8'h5A, then ena = 0 with mode 01 for 4 cycles -> q = 8'h5A and shift_cnt = 0 unchanged.
- USR_ROTATE_EN: load 8'h81, rot = 1, shift right 1 cycle -> q = 8'hC0; shift left 2 cycles -> q = 8'h03.
